// File: rtl/interrupt_sequencer.sv
// CPU-side responder for the interrupt controller handle/clear handshake.
// Defers entry to an instruction boundary and keeps a LIFO of {return pc, id}.
module interrupt_sequencer #(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] VECTOR_BASE  = 16'hFF00,
  parameter int          VECTOR_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         int_enable,
  input  logic                         instr_boundary,
  input  logic [15:0]                  pc_in,
  input  logic                         rti,
  input  logic                         cpu_interrupt,
  input  logic [3:0]                   cpu_interrupt_id,
  output logic                         handle_interrupt,
  output logic                         clear_interrupt,
  output logic [3:0]                   clear_interrupt_id,
  output logic                         pc_load,
  output logic [15:0]                  pc_load_value,
  output logic                         in_interrupt,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         protocol_error
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] LATCHED = 1'b1;

  logic [0:0]    state_reg;
  logic [DW-1:0] depth_reg;
  logic [3:0]    id_reg;
  logic          clear_reg;
  logic [3:0]    clear_id_reg;
  logic          pc_load_reg;
  logic [15:0]   pc_load_value_reg;
  logic          error_reg;

  logic [15:0] stack_pc [DEPTH];
  logic [3:0]  stack_id [DEPTH];

  logic          stack_full;
  logic          stack_empty;
  logic          do_pop;
  logic          do_take;
  logic          do_accept;
  logic          do_error;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;
  logic [15:0]   vector;

  assign stack_full  = (depth_reg == DW'(DEPTH));
  assign stack_empty = (depth_reg == '0);
  assign push_idx    = AW'(depth_reg);
  assign pop_idx     = AW'(depth_reg - DW'(1));
  assign vector      = VECTOR_BASE + (16'(id_reg) << VECTOR_SHIFT);

  // A return always wins over a take on the same edge; the take simply waits.
  assign do_pop    = rti & ~stack_empty;
  assign do_take   = (state_reg == LATCHED) & instr_boundary & ~do_pop;
  assign do_accept = (state_reg == IDLE) & cpu_interrupt & ~stack_full;
  assign do_error  = (rti & stack_empty)
                   | (cpu_interrupt & ((state_reg == LATCHED) | stack_full));

  assign handle_interrupt = (state_reg == IDLE) & int_enable & ~stack_full
                          & ~cpu_interrupt & ~clear_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      depth_reg         <= '0;
      id_reg            <= '0;
      clear_reg         <= 1'b0;
      clear_id_reg      <= '0;
      pc_load_reg       <= 1'b0;
      pc_load_value_reg <= '0;
      error_reg         <= 1'b0;
    end else begin
      clear_reg   <= 1'b0;
      pc_load_reg <= 1'b0;
      if (do_pop) begin
        depth_reg         <= depth_reg - DW'(1);
        pc_load_reg       <= 1'b1;
        pc_load_value_reg <= stack_pc[pop_idx];
        clear_reg         <= 1'b1;
        clear_id_reg      <= stack_id[pop_idx];
      end else if (do_take) begin
        depth_reg         <= depth_reg + DW'(1);
        pc_load_reg       <= 1'b1;
        pc_load_value_reg <= vector;
        state_reg         <= IDLE;
      end
      if (do_accept) begin
        id_reg    <= cpu_interrupt_id;
        state_reg <= LATCHED;
      end
      if (do_error) begin
        error_reg <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset_n && do_take) begin
      stack_pc[push_idx] <= pc_in;
      stack_id[push_idx] <= id_reg;
    end
  end

  assign clear_interrupt    = clear_reg;
  assign clear_interrupt_id = clear_id_reg;
  assign pc_load            = pc_load_reg;
  assign pc_load_value      = pc_load_value_reg;
  assign in_interrupt       = ~stack_empty;
  assign depth              = depth_reg;
  assign protocol_error     = error_reg;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
CPU-side responder for the interrupt controller's handle/clear handshake. It drives handle_interrupt and accepts the committed interrupt id, then defers entry to an instruction boundary. At entry it pushes the return PC and id onto a nesting stack and loads the vector PC. On return-from-interrupt it pops the stack, restores the PC and issues clear_interrupt with the popped id. It sits between the interrupt controller and the CPU fetch/PC logic.

Parameters:
DEPTH, 4, max nesting depth (stack entries of {pc[15:0], id[3:0]}).
VECTOR_BASE, 16'hFF00, vector address of id 0.
VECTOR_SHIFT, 2, vector stride = 1<<VECTOR_SHIFT words; vector = VECTOR_BASE + (id << VECTOR_SHIFT), 16-bit wrap.

Ports:
clk  in  1  system clock, all state on posedge.
reset_n  in  1  synchronous, active-low reset.
int_enable  in  1  global interrupt enable from status register.
instr_boundary  in  1  CPU is between instructions; safe to redirect PC.
pc_in  in  16  return PC captured at take.
rti  in  1  one-cycle pulse: return-from-interrupt executed.
cpu_interrupt  in  1  controller: interrupt committed (pulse).
cpu_interrupt_id  in  4  controller: committed id, valid with cpu_interrupt.
handle_interrupt  out  1  permission for controller to commit next interrupt (combinational).
clear_interrupt  out  1  registered one-cycle pulse: retire clear_interrupt_id.
clear_interrupt_id  out  4  id being retired.
pc_load  out  1  registered one-cycle pulse: PC <= pc_load_value.
pc_load_value  out  16  vector or restored PC.
in_interrupt  out  1  depth != 0.
depth  out  $clog2(DEPTH+1)  current stack occupancy.
protocol_error  out  1  sticky error flag.

Behaviour:
- Reset (reset_n low at edge): state IDLE, depth 0, latched id 0. clear_interrupt, pc_load and protocol_error are 0. pc_load_value and clear_interrupt_id are 0. Stack contents are don't-care. The controller is not reset by this block; the system resets both.
- States: IDLE, LATCHED.
- handle_interrupt = (state==IDLE) & int_enable & (depth<DEPTH) & ~cpu_interrupt & ~clear_interrupt. The ~cpu_interrupt term prevents a second commit in the same cycle. The ~clear_interrupt term is required because a clear in the controller suppresses its cpu_interrupt, which would lose a commit.
- IDLE: cpu_interrupt sampled high -> latch id, go to LATCHED.
- LATCHED: instr_boundary sampled high and no rti accepted this edge -> take.
  - Push {pc_in, latched id}; depth+1.
  - Next cycle: pc_load=1, pc_load_value = vector(id).
  - Return to IDLE.
- rti sampled high with depth>0 (any state) -> pop top entry; depth-1.
  - Next cycle: pc_load=1, pc_load_value = popped pc, clear_interrupt=1, clear_interrupt_id = popped id.
  - State is unchanged.
- rti and take on the same edge: rti wins, take is deferred; state stays LATCHED and the take fires at the next boundary.
- rti and cpu_interrupt on the same edge in IDLE: both are honoured (pop plus latch).
- Error cases, all setting protocol_error (sticky until reset):
  - rti at depth 0: ignored, no pulses.
  - cpu_interrupt sampled while in LATCHED: ignored.
  - cpu_interrupt while depth==DEPTH: ignored.
- Latency: cpu_interrupt to LATCHED is 1 edge. Boundary to pc_load is 1 cycle. rti to clear/pc_load is 1 cycle.
- Pulse widths: pc_load and clear_interrupt never exceed one cycle; at most one pc_load source per cycle.
- int_enable low does not cancel LATCHED; a latched interrupt is always taken.

Test Plan:
1. int_enable=1, IDLE: handle_interrupt=1. Drive cpu_interrupt, id=3 -> handle_interrupt=0 that cycle, LATCHED. Then instr_boundary with pc_in=0x0123 -> next cycle pc_load=1, value 0xFF0C, depth=1. Then rti -> clear_interrupt=1, id=3, pc_load value 0x0123, depth=0.
2. Nesting: take id 2 (pc 0x0100), then id 7 (pc 0x0200). First rti -> id 7, 0x0200. Second rti -> id 2, 0x0100 (LIFO).
3. Four takes with DEPTH=4 -> handle_interrupt stays 0 with int_enable=1. An injected cpu_interrupt raises protocol_error.
4. LATCHED id 5, depth=1, rti and instr_boundary on the same edge -> next cycle clear_interrupt with old id and restored PC. Next boundary -> pc_load 0xFF14.
5. rti at depth 0 -> no clear_interrupt, no pc_load, protocol_error=1. Any cycle with clear_interrupt=1 -> handle_interrupt=0.
6. reset_n=0 while LATCHED with depth=2 -> next edge: state IDLE, depth 0, all outputs 0.
